full_adder: RTL and testbench



---
 rtl/full_adder.sv | 116 +++++++++++
 tb/tb_full_adder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//
// Single-bit full adder with an optional bit-serial accumulation mode.
// In combinational mode (serial_en=0) the carry-in comes from port c. In
// serial mode (serial_en=1) it comes from an internal carry register that is
// loaded from c on a start pulse and then updated with the carry-out on every
// accumulate edge. Operands are fed LSB first, one bit per clock. The sum
// bits are shifted into result from the top, so the first bit lands in
// result[0] after WIDTH shifts.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   a, b      in   addend bits
//   c         in   carry-in (combinational) / initial carry (serial start)
//   serial_en in   1 = carry-in from the carry register, 0 = from c
//   start     in   single-cycle pulse that begins a serial addition
//   sum       out  combinational sum bit
//   carry     out  combinational carry-out bit
//   sum_q     out  sum registered every clock edge
//   carry_q   out  carry registered every clock edge
//   result    out  WIDTH-bit serial sum word
//   done      out  high once WIDTH serial bits have been accumulated
// -----------------------------------------------------------------------------
module full_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             serial_en,
   input  logic             start,
   output logic             sum,
   output logic             carry,
   output logic             sum_q,
   output logic             carry_q,
   output logic [WIDTH-1:0] result,
   output logic             done
);

   // WIDTH=1 still needs a one-bit counter.
   localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic             creg_q, creg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             done_q, done_d;

   logic             cin_sel;
   logic             start_edge;
   logic             acc_edge;
   logic [WIDTH-1:0] res_shift;

   // Combinational full adder.
   always_comb begin
      cin_sel = serial_en ? creg_q : c;
      sum     = a ^ b ^ cin_sel;
      carry   = (a & b) | (a & cin_sel) | (b & cin_sel);
   end

   // Serial-mode next state. Start has priority over accumulation; clearing
   // serial_en simply holds everything (pause).
   always_comb begin
      start_edge = serial_en & start;
      acc_edge   = serial_en & ~start & ~done_q;

      // Written without a part-select so WIDTH=1 is legal.
      res_shift            = res_q >> 1;
      res_shift[WIDTH-1]   = sum;

      creg_d = creg_q;
      cnt_d  = cnt_q;
      res_d  = res_q;
      done_d = done_q;

      if (start_edge) begin
         creg_d = c;
         cnt_d  = '0;
         res_d  = '0;
         done_d = 1'b0;
      end else if (acc_edge) begin
         creg_d = carry;
         cnt_d  = cnt_q + 1'b1;
         res_d  = res_shift;
         if (cnt_q == LAST) begin
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q   <= 1'b0;
         carry_q <= 1'b0;
         creg_q  <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         sum_q   <= sum;
         carry_q <= carry;
         creg_q  <= creg_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         done_q  <= done_d;
      end
   end

   assign result = res_q;
   assign done   = done_q;

endmodule

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder
//
// Directed plus randomized bench for full_adder. Expected values come from
// plain integer addition: a serial add of A, B with carry-in cin must yield
// (A + B + cin) mod 2**W in result and bit W as the final carry.
// -----------------------------------------------------------------------------
module tb_full_adder;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         a, b, c;
   logic         serial_en;
   logic         start;
   logic         sum, carry;
   logic         sum_q, carry_q;
   logic [W-1:0] result;
   logic         done;

   int checks = 0;
   int errors = 0;

   full_adder #(
      .WIDTH(W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .a        (a),
      .b        (b),
      .c        (c),
      .serial_en(serial_en),
      .start    (start),
      .sum      (sum),
      .carry    (carry),
      .sum_q    (sum_q),
      .carry_q  (carry_q),
      .result   (result),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs are driven 1 ns after the rising edge, well clear of it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: serial sum of A+B+cin with only the low i bits accumulated,
   // which sit at the top of the shift register.
   function automatic logic [W-1:0] partial(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                            input logic cin, input int i);
      longint unsigned s, m;
      s = longint'(aa) + longint'(bb) + longint'(cin);
      m = (64'd1 << i) - 64'd1;
      return W'((s & m) << (W - i));
   endfunction

   function automatic logic final_carry(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                        input logic cin);
      longint unsigned s;
      s = longint'(aa) + longint'(bb) + longint'(cin);
      return s[W];
   endfunction

   task automatic do_start(input logic cin);
      serial_en = 1'b1;
      start     = 1'b1;
      c         = cin;
      a         = 1'($urandom);
      b         = 1'($urandom);
      tick();
      start = 1'b0;
      c     = 1'($urandom);   // ignored while serial_en=1
   endtask

   // Feed bits [from, to); optionally drop serial_en before bit pause_at.
   task automatic feed(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cin,
                       input int from, input int to, input int pause_at, input int pause_len);
      for (int i = from; i < to; i++) begin
         if (i == pause_at) begin
            serial_en = 1'b0;
            for (int p = 0; p < pause_len; p++) begin
               tick();
               chk("pause_hold", 64'(result), 64'(partial(aa, bb, cin, i)));
            end
            serial_en = 1'b1;
         end
         a = aa[i];
         b = bb[i];
         if (i == W - 1) begin
            #1 chk("done_before_last", 64'(done), 64'd0);
         end
         tick();
      end
   endtask

   task automatic finish_chk(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cin);
      logic [W-1:0] er;
      er = partial(aa, bb, cin, W);
      chk("serial_result", 64'(result), 64'(er));
      chk("serial_done", 64'(done), 64'd1);
      // With a=1,b=0 the combinational carry equals the carry register.
      serial_en = 1'b1;
      a = 1'b1;
      b = 1'b0;
      #1 chk("final_carry", 64'(carry), 64'(final_carry(aa, bb, cin)));
      tick();
      chk("hold_after_done", 64'(result), 64'(er));
      chk("carry_hold", 64'(carry), 64'(final_carry(aa, bb, cin)));
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic         rc;
      int           s;

      rst_n     = 1'b0;
      a         = 1'b0;
      b         = 1'b0;
      c         = 1'b0;
      serial_en = 1'b0;
      start     = 1'b0;

      #2;
      chk("rst_sum_q", 64'(sum_q), 64'd0);
      chk("rst_carry_q", 64'(carry_q), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      #20 rst_n = 1'b1;

      // Combinational sweep of all eight input patterns.
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         {a, b, c} = v;
         #1;
         s = int'(v[2]) + int'(v[1]) + int'(v[0]);
         chk("comb_sum", 64'(sum), 64'(s % 2));
         chk("comb_carry", 64'(carry), 64'(s / 2));
         #9;
      end

      // Registered copy: one-cycle latency.
      tick();
      {a, b, c} = 3'b000;
      tick();
      chk("reg_sum_q0", 64'(sum_q), 64'd0);
      chk("reg_carry_q0", 64'(carry_q), 64'd0);
      {a, b, c} = 3'b110;
      #1;
      chk("reg_carry_q_before", 64'(carry_q), 64'd0);
      tick();
      chk("reg_sum_q", 64'(sum_q), 64'd0);
      chk("reg_carry_q", 64'(carry_q), 64'd1);

      // Randomized combinational and registered checks.
      for (int n = 0; n < 16; n++) begin
         {a, b, c} = 3'($urandom);
         #1;
         s = int'(a) + int'(b) + int'(c);
         chk("rnd_sum", 64'(sum), 64'(s % 2));
         chk("rnd_carry", 64'(carry), 64'(s / 2));
         tick();
         chk("rnd_sum_q", 64'(sum_q), 64'(s % 2));
         chk("rnd_carry_q", 64'(carry_q), 64'(s / 2));
      end

      // Directed serial adds.
      do_start(1'b0);
      feed(8'hA5, 8'h3C, 1'b0, 0, W, -1, 0);
      finish_chk(8'hA5, 8'h3C, 1'b0);

      do_start(1'b0);
      feed(8'hFF, 8'h01, 1'b0, 0, W, -1, 0);
      finish_chk(8'hFF, 8'h01, 1'b0);

      do_start(1'b0);
      feed(8'h0F, 8'h01, 1'b0, 0, W, 3, 3);
      finish_chk(8'h0F, 8'h01, 1'b0);

      // Start during accumulation clears and restarts with the new carry.
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_start(1'b0);
      feed(ra, rb, 1'b0, 0, 3, -1, 0);
      serial_en = 1'b1;
      start     = 1'b1;
      c         = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_result", 64'(result), 64'd0);
      chk("restart_done", 64'(done), 64'd0);
      ra = 8'($urandom);
      rb = 8'($urandom);
      feed(ra, rb, 1'b1, 0, W, -1, 0);
      finish_chk(ra, rb, 1'b1);

      // Start with serial_en=0 is ignored.
      serial_en = 1'b0;
      start     = 1'b1;
      tick();
      start = 1'b0;
      chk("start_ignored_done", 64'(done), 64'd1);

      // Randomized serial adds with random pauses.
      for (int n = 0; n < 6; n++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         do_start(rc);
         feed(ra, rb, rc, 0, W, int'($urandom_range(0, W)), int'($urandom_range(1, 3)));
         finish_chk(ra, rb, rc);
      end

      // Async reset mid-add, between clock edges.
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_start(1'b1);
      feed(ra, rb, 1'b1, 0, 5, -1, 0);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_sum_q", 64'(sum_q), 64'd0);
      chk("arst_carry_q", 64'(carry_q), 64'd0);
      chk("arst_result", 64'(result), 64'd0);
      chk("arst_done", 64'(done), 64'd0);
      serial_en = 1'b0;
      {a, b, c} = 3'b101;
      #1;
      chk("arst_comb_sum", 64'(sum), 64'd0);
      chk("arst_comb_carry", 64'(carry), 64'd1);
      serial_en = 1'b1;
      {a, b, c} = 3'b101;
      #1;
      // Carry register is cleared, so c is not used.
      chk("arst_creg_sum", 64'(sum), 64'd1);
      chk("arst_creg_carry", 64'(carry), 64'd0);
      #1 rst_n = 1'b1;
      serial_en = 1'b0;
      tick();

      // Fresh add after reset.
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_start(1'b0);
      feed(ra, rb, 1'b0, 0, W, -1, 0);
      finish_chk(ra, rb, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
